// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: forwarding, load-use/scoreboard stalls and redirect flush; define HAZARD_PERF_CNT_EN for stall/flush perf counters
module hazard_ctrl_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int MC_MAX       = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dec_valid,
  input  logic                  dec_is_mc,
  input  logic [REG_ADDR_W-1:0] dec_rs1_addr,
  input  logic [REG_ADDR_W-1:0] dec_rs2_addr,
  input  logic [REG_ADDR_W-1:0] ex_rs1_addr,
  input  logic [REG_ADDR_W-1:0] ex_rs2_addr,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_reg_write,
  input  logic                  mc_issue,
  input  logic [REG_ADDR_W-1:0] mc_issue_rd,
  input  logic                  mc_done,
  input  logic [REG_ADDR_W-1:0] mc_done_rd,
  input  logic                  pc_select,
  output logic [1:0]            forward_alu_a,
  output logic [1:0]            forward_alu_b,
  output logic                  stall_fetch,
  output logic                  stall_decode,
  output logic                  flush_fetch_decode,
  output logic                  flush_dec_ex,
  output logic                  sb_full,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_cycles
);
  localparam int NREG = 2 ** REG_ADDR_W;
  typedef enum logic {RUN, REDIRECT} state_t;
  state_t          state_q, state_d;
  logic [2:0]      fcnt_q, fcnt_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic [3:0]      out_q, out_d;
  logic            issue_ok, done_ok, load_use, sb_hazard, hazard;
  assign forward_alu_a = ex_rs1_addr == '0 ? 2'b00 :
                         mem_reg_write && mem_rd_addr == ex_rs1_addr ? 2'b11 :
                         wb_reg_write && wb_rd_addr == ex_rs1_addr ? 2'b10 : 2'b00;
  assign forward_alu_b = ex_rs2_addr == '0 ? 2'b00 :
                         mem_reg_write && mem_rd_addr == ex_rs2_addr ? 2'b11 :
                         wb_reg_write && wb_rd_addr == ex_rs2_addr ? 2'b10 : 2'b00;
  assign sb_full   = out_q == 4'(MC_MAX);
  assign issue_ok  = mc_issue && mc_issue_rd != '0 && !sb_full;
  assign done_ok   = mc_done && pending_q[mc_done_rd];
  assign load_use  = dec_valid && ex_mem_read && ex_rd_addr != '0 &&
                     ((dec_rs1_addr != '0 && dec_rs1_addr == ex_rd_addr) ||
                      (dec_rs2_addr != '0 && dec_rs2_addr == ex_rd_addr));
  assign sb_hazard = dec_valid && ((dec_rs1_addr != '0 && pending_q[dec_rs1_addr]) ||
                                   (dec_rs2_addr != '0 && pending_q[dec_rs2_addr]) ||
                                   (dec_is_mc && sb_full));
  assign hazard    = load_use || sb_hazard;
  // A redirect overrides any stall; the execute bubble still follows the hazard.
  assign flush_fetch_decode = pc_select || state_q == REDIRECT;
  assign flush_dec_ex       = pc_select || hazard;
  assign stall_fetch        = hazard && !flush_fetch_decode;
  assign stall_decode       = hazard && !flush_fetch_decode;
  always_comb begin
    pending_d = pending_q;
    if (done_ok) pending_d[mc_done_rd] = 1'b0;
    if (issue_ok) pending_d[mc_issue_rd] = 1'b1;
    out_d = out_q + 4'(issue_ok) - 4'(done_ok);
  end
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (pc_select) begin
      fcnt_d  = 3'(FLUSH_CYCLES - 1);
      state_d = FLUSH_CYCLES > 1 ? REDIRECT : RUN;
    end else if (state_q == REDIRECT) begin
      fcnt_d  = fcnt_q - 3'd1;
      state_d = fcnt_d == 3'd0 ? RUN : REDIRECT;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      fcnt_q    <= '0;
      pending_q <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      pending_q <= pending_d;
      out_q     <= out_d;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_decode && !(&stall_cnt_q)};
    flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, flush_fetch_decode && !(&flush_cnt_q)};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif
endmodule
